// File: rtl/ans_pkg.sv
// Shared constants and controller state encoding for the ANS session path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ans_pkg;

    localparam int SYM_WIDTH   = 4;   // nibble / symbol width
    localparam int SYM_COUNT   = 4;   // alphabet size
    localparam int CNT_WIDTH   = 4;   // bits per frequency count
    localparam int LEN_WIDTH   = 8;   // symbol-count field width
    localparam int TABLE_TOTAL = 16;  // required sum of all counts

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TAB = 3'd1,
        LOAD_LEN = 3'd2,
        CHECK    = 3'd3,
        DEC_RST  = 3'd4,
        STREAM   = 3'd5,
        DONE     = 3'd6,
        ERROR    = 3'd7
    } ctrl_state_t;

endpackage : ans_pkg

// File: rtl/ans_table_sum.sv
// Adds up every frequency count of a packed table, wide enough never to overflow.
// Latency: combinational.
// Backpressure: none.
// Ports: counts_i - packed table, count i at [i*CNT_WIDTH +: CNT_WIDTH]; sum_o - total.
module ans_table_sum #(
    parameter int SYM_COUNT = 4,
    parameter int CNT_WIDTH = 4,
    parameter int SUM_WIDTH = CNT_WIDTH + $clog2(SYM_COUNT)
) (
    input  logic [SYM_COUNT*CNT_WIDTH-1:0] counts_i,
    output logic [SUM_WIDTH-1:0]           sum_o
);

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < SYM_COUNT; i++) begin
            sum_o = sum_o + SUM_WIDTH'(counts_i[i*CNT_WIDTH +: CNT_WIDTH]);
        end
    end

endmodule : ans_table_sum

// File: rtl/ans_session_ctrl.sv
// Frames the host nibble stream for ans_decoder: loads table + length, validates, resets decoder, streams.
// Latency: STREAM is a zero-latency pass-through; setup takes table+length nibbles plus CHECK and DEC_RST cycles.
// Backpressure: valid/ready on every port; en=0 freezes all state and forces every vld/rdy output low.
// Ports: clk/rst_n/en/start control; host_* host nibble in; dec_in* toward decoder; dec_out* from decoder;
//        sym_* toward consumer; counts_unpacked table to decoder; dec_rst_n decoder reset; busy/done/err status.
module ans_session_ctrl
    import ans_pkg::*;
#(
    parameter int SYM_WIDTH   = ans_pkg::SYM_WIDTH,
    parameter int SYM_COUNT   = ans_pkg::SYM_COUNT,
    parameter int CNT_WIDTH   = ans_pkg::CNT_WIDTH,
    parameter int LEN_WIDTH   = ans_pkg::LEN_WIDTH,
    parameter int TABLE_TOTAL = ans_pkg::TABLE_TOTAL
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           start,
    input  logic [SYM_WIDTH-1:0]           host_in,
    input  logic                           host_vld,
    output logic                           host_rdy,
    output logic [SYM_WIDTH-1:0]           dec_in,
    output logic                           dec_in_vld,
    input  logic                           dec_in_rdy,
    input  logic [SYM_WIDTH-1:0]           dec_out,
    input  logic                           dec_out_vld,
    output logic                           dec_out_rdy,
    output logic [SYM_WIDTH-1:0]           sym_out,
    output logic                           sym_vld,
    input  logic                           sym_rdy,
    output logic [SYM_COUNT*CNT_WIDTH-1:0] counts_unpacked,
    output logic                           dec_rst_n,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int TAB_NIB   = SYM_COUNT * CNT_WIDTH / SYM_WIDTH;
    localparam int LEN_NIB   = LEN_WIDTH / SYM_WIDTH;
    localparam int MAX_NIB   = (TAB_NIB > LEN_NIB) ? TAB_NIB : LEN_NIB;
    localparam int IDX_W     = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;
    localparam int SUM_WIDTH = CNT_WIDTH + $clog2(SYM_COUNT);

    ctrl_state_t                    state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [SYM_COUNT*CNT_WIDTH-1:0] counts_q, counts_d;
    logic [LEN_WIDTH-1:0]           rem_q, rem_d;
    logic                           err_q, err_d;
    logic                           dec_rst_flag_q;
    logic [SUM_WIDTH-1:0]           tab_sum;
    logic                           host_fire;
    logic                           sym_fire;

    ans_table_sum #(
        .SYM_COUNT (SYM_COUNT),
        .CNT_WIDTH (CNT_WIDTH),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_table_sum (
        .counts_i (counts_q),
        .sum_o    (tab_sum)
    );

    // Handshake outputs; every vld/rdy is qualified by en so nothing moves while frozen.
    always_comb begin
        host_rdy    = 1'b0;
        dec_in      = '0;
        dec_in_vld  = 1'b0;
        dec_out_rdy = 1'b0;
        sym_out     = '0;
        sym_vld     = 1'b0;
        unique case (state_q)
            LOAD_TAB, LOAD_LEN: begin
                host_rdy = en;
            end
            STREAM: begin
                dec_in      = host_in;
                dec_in_vld  = en & host_vld;
                host_rdy    = en & dec_in_rdy;
                sym_out     = dec_out;
                sym_vld     = en & dec_out_vld;
                dec_out_rdy = en & sym_rdy;
            end
            default: ;
        endcase
    end

    assign host_fire = host_vld & host_rdy;
    assign sym_fire  = sym_vld & sym_rdy;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        counts_d = counts_q;
        rem_d    = rem_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = LOAD_TAB;
                end
            end
            LOAD_TAB: begin
                if (host_fire) begin
                    counts_d[idx_q*SYM_WIDTH +: SYM_WIDTH] = host_in;
                    if (idx_q == IDX_W'(TAB_NIB - 1)) begin
                        idx_d   = '0;
                        state_d = LOAD_LEN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            LOAD_LEN: begin
                // Little-endian: the first nibble lands in the least significant slot.
                if (host_fire) begin
                    rem_d[idx_q*SYM_WIDTH +: SYM_WIDTH] = host_in;
                    if (idx_q == IDX_W'(LEN_NIB - 1)) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CHECK: begin
                if ((tab_sum != SUM_WIDTH'(TABLE_TOTAL)) || (rem_q == '0)) begin
                    // err goes up on entry so it is visible during the ERROR cycle.
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    state_d = DEC_RST;
                end
            end
            DEC_RST: begin
                state_d = STREAM;
            end
            STREAM: begin
                if (sym_fire) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERROR: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            counts_q       <= '0;
            rem_q          <= '0;
            err_q          <= 1'b0;
            dec_rst_flag_q <= 1'b1;
        end else if (en) begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            counts_q       <= counts_d;
            rem_q          <= rem_d;
            err_q          <= err_d;
            // Low for exactly the cycle spent in DEC_RST.
            dec_rst_flag_q <= (state_d != DEC_RST);
        end
    end

    assign counts_unpacked = counts_q;
    assign dec_rst_n       = rst_n & dec_rst_flag_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign err             = err_q;

endmodule : ans_session_ctrl

// File: tb/tb_ans_session_ctrl.sv
module tb_ans_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        start;
    logic [3:0]  host_in;
    logic        host_vld;
    logic        host_rdy;
    logic [3:0]  dec_in;
    logic        dec_in_vld;
    logic        dec_in_rdy;
    logic [3:0]  dec_out;
    logic        dec_out_vld;
    logic        dec_out_rdy;
    logic [3:0]  sym_out;
    logic        sym_vld;
    logic        sym_rdy;
    logic [15:0] counts_unpacked;
    logic        dec_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    ans_session_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .start           (start),
        .host_in         (host_in),
        .host_vld        (host_vld),
        .host_rdy        (host_rdy),
        .dec_in          (dec_in),
        .dec_in_vld      (dec_in_vld),
        .dec_in_rdy      (dec_in_rdy),
        .dec_out         (dec_out),
        .dec_out_vld     (dec_out_vld),
        .dec_out_rdy     (dec_out_rdy),
        .sym_out         (sym_out),
        .sym_vld         (sym_vld),
        .sym_rdy         (sym_rdy),
        .counts_unpacked (counts_unpacked),
        .dec_rst_n       (dec_rst_n),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        host_in  = n;
        host_vld = 1'b1;
        #1;
        chk("host_rdy_load", 32'(host_rdy), 32'd1);
        tick();
        host_vld = 1'b0;
    endtask

    // Starts a frame and loads 4 table nibbles and 2 length nibbles; returns in CHECK.
    task automatic load_frame(input logic [3:0] t0, input logic [3:0] t1, input logic [3:0] t2,
                              input logic [3:0] t3, input logic [3:0] l0, input logic [3:0] l1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_nib(t0);
        send_nib(t1);
        send_nib(t2);
        send_nib(t3);
        send_nib(l0);
        send_nib(l1);
    endtask

    initial begin
        rst_n       = 1'b1;
        en          = 1'b1;
        start       = 1'b0;
        host_in     = '0;
        host_vld    = 1'b0;
        dec_in_rdy  = 1'b0;
        dec_out     = '0;
        dec_out_vld = 1'b0;
        sym_rdy     = 1'b0;
        #1 rst_n = 1'b0;
        #2;

        // ---------------- reset state ----------------
        chk("rst_busy",     32'(busy),            32'd0);
        chk("rst_host_rdy", 32'(host_rdy),        32'd0);
        chk("rst_dec_rst",  32'(dec_rst_n),       32'd0);
        chk("rst_counts",   32'(counts_unpacked), 32'd0);
        chk("rst_done",     32'(done),            32'd0);
        chk("rst_err",      32'(err),             32'd0);
        chk("rst_vlds",     32'({dec_in_vld, dec_out_rdy, sym_vld}), 32'd0);
        chk("rst_data",     32'({dec_in, sym_out}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rst_rel_dec_rst", 32'(dec_rst_n), 32'd1);
        tick();

        // ---------------- happy path ----------------
        load_frame(4'd4, 4'd4, 4'd4, 4'd4, 4'd3, 4'd0);
        chk("hp_check_host_rdy", 32'(host_rdy),  32'd0);
        chk("hp_check_dec_rst",  32'(dec_rst_n), 32'd1);
        tick();
        chk("hp_decrst_low",  32'(dec_rst_n), 32'd0);
        chk("hp_decrst_busy", 32'(busy),      32'd1);
        tick();
        chk("hp_stream_dec_rst", 32'(dec_rst_n),       32'd1);
        chk("hp_counts",         32'(counts_unpacked), 32'h4444);
        chk("hp_rem_init",       32'(dut.rem_q),       32'd3);
        dec_out     = 4'd1;
        dec_out_vld = 1'b1;
        sym_rdy     = 1'b1;
        host_in     = 4'd7;
        host_vld    = 1'b1;
        dec_in_rdy  = 1'b1;
        #1;
        chk("hp_sym_vld",     32'(sym_vld),     32'd1);
        chk("hp_sym_out1",    32'(sym_out),     32'd1);
        chk("hp_dec_out_rdy", 32'(dec_out_rdy), 32'd1);
        chk("hp_dec_in",      32'(dec_in),      32'd7);
        chk("hp_dec_in_vld",  32'(dec_in_vld),  32'd1);
        chk("hp_host_rdy_st", 32'(host_rdy),    32'd1);
        tick();
        host_vld = 1'b0;
        dec_out  = 4'd2;
        #1;
        chk("hp_sym_out2", 32'(sym_out),   32'd2);
        chk("hp_rem2",     32'(dut.rem_q), 32'd2);
        chk("hp_done_mid", 32'(done),      32'd0);
        tick();
        dec_out = 4'd3;
        #1;
        chk("hp_sym_out3", 32'(sym_out), 32'd3);
        tick();
        host_in  = 4'd9;
        host_vld = 1'b1;
        #1;
        chk("hp_done",          32'(done),        32'd1);
        chk("hp_done_host_rdy", 32'(host_rdy),    32'd0);
        chk("hp_done_sym_vld",  32'(sym_vld),     32'd0);
        chk("hp_done_out_rdy",  32'(dec_out_rdy), 32'd0);
        tick();
        chk("hp_done_once",     32'(done),            32'd0);
        chk("hp_idle_busy",     32'(busy),            32'd0);
        chk("hp_idle_host_rdy", 32'(host_rdy),        32'd0);
        chk("hp_counts_hold",   32'(counts_unpacked), 32'h4444);
        host_vld    = 1'b0;
        dec_out_vld = 1'b0;
        sym_rdy     = 1'b0;
        dec_in_rdy  = 1'b0;

        // ---------------- bad table (sum 17) ----------------
        load_frame(4'd5, 4'd4, 4'd4, 4'd4, 4'd2, 4'd0);
        chk("bt_check_dec_rst", 32'(dec_rst_n), 32'd1);
        tick();
        chk("bt_err",         32'(err),       32'd1);
        chk("bt_err_dec_rst", 32'(dec_rst_n), 32'd1);
        chk("bt_err_busy",    32'(busy),      32'd1);
        tick();
        chk("bt_idle_busy", 32'(busy),      32'd0);
        chk("bt_err_held",  32'(err),       32'd1);
        chk("bt_idle_drst", 32'(dec_rst_n), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bt_err_cleared", 32'(err), 32'd0);

        // ---------------- zero length ----------------
        send_nib(4'd4);
        send_nib(4'd4);
        send_nib(4'd4);
        send_nib(4'd4);
        send_nib(4'd0);
        send_nib(4'd0);
        tick();
        chk("zl_err",         32'(err),       32'd1);
        chk("zl_err_busy",    32'(busy),      32'd1);
        chk("zl_err_dec_rst", 32'(dec_rst_n), 32'd1);
        tick();
        chk("zl_idle_busy", 32'(busy), 32'd0);

        // ---------------- backpressure / enable ----------------
        load_frame(4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0);
        tick();
        tick();
        dec_out     = 4'd2;
        dec_out_vld = 1'b1;
        sym_rdy     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_dec_out_rdy", 32'(dec_out_rdy), 32'd0);
            chk("bp_rem",         32'(dut.rem_q),   32'd5);
            tick();
        end
        en         = 1'b0;
        sym_rdy    = 1'b1;
        host_vld   = 1'b1;
        dec_in_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("en_host_rdy",    32'(host_rdy),    32'd0);
            chk("en_dec_in_vld",  32'(dec_in_vld),  32'd0);
            chk("en_dec_out_rdy", 32'(dec_out_rdy), 32'd0);
            chk("en_sym_vld",     32'(sym_vld),     32'd0);
            tick();
        end
        chk("en_rem",     32'(dut.rem_q), 32'd5);
        chk("en_busy",    32'(busy),      32'd1);
        chk("en_state",   32'(dut.state_q), 32'd5);
        en       = 1'b1;
        host_vld = 1'b0;
        tick();
        tick();
        chk("bp_rem_after2", 32'(dut.rem_q), 32'd3);

        // ---------------- reset mid-stream ----------------
        rst_n = 1'b0;
        #1;
        chk("mr_busy",     32'(busy),            32'd0);
        chk("mr_counts",   32'(counts_unpacked), 32'd0);
        chk("mr_dec_rst",  32'(dec_rst_n),       32'd0);
        chk("mr_rem",      32'(dut.rem_q),       32'd0);
        chk("mr_out_rdy",  32'(dec_out_rdy),     32'd0);
        @(negedge clk) rst_n = 1'b1;
        dec_out_vld = 1'b0;
        tick();

        load_frame(4'd8, 4'd4, 4'd2, 4'd2, 4'd1, 4'd0);
        tick();
        chk("nf_decrst_low", 32'(dec_rst_n), 32'd0);
        tick();
        chk("nf_counts", 32'(counts_unpacked), 32'h2248);
        dec_out     = 4'd5;
        dec_out_vld = 1'b1;
        #1;
        chk("nf_sym_out", 32'(sym_out), 32'd5);
        tick();
        dec_out_vld = 1'b0;
        chk("nf_done", 32'(done), 32'd1);
        tick();
        chk("nf_done_clr", 32'(done), 32'd0);
        chk("nf_idle",     32'(busy), 32'd0);
        chk("nf_err",      32'(err),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ans_session_ctrl
